// File: rtl/mdu_iter.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Latency: WIDTH+1 edges from accepted start to result; done pulses on the result edge.
// Backpressure: start is ignored while busy; no queuing, the controller stalls on busy.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_w,
    input  logic             lo_w,
    input  logic [WIDTH-1:0] w_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 div_q, div_d;
    logic                 neg_q, neg_d;
    logic                 rneg_q, rneg_d;
    logic [WIDTH-1:0]     a_orig_q, a_orig_d;
    logic [WIDTH-1:0]     mb_q, mb_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH+1:0]     div_sh, div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    // Signed ops run on magnitudes; the signs are reapplied in FIX.
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign abs_a = a_neg ? -a : a;
    assign abs_b = b_neg ? -b : b;

    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mb_q} : {(WIDTH+1){1'b0}});

    // Partial remainder stays below the divisor, so the extra top bit makes the borrow a clean sign.
    assign div_sh   = {rem_q, acc_q[WIDTH-1]};
    assign div_diff = div_sh - {2'b00, mb_q};
    assign div_ge   = ~div_diff[WIDTH+1];

    assign prod_fix = neg_q  ? -acc_q                : acc_q;
    assign quo_fix  = neg_q  ? -acc_q[WIDTH-1:0]     : acc_q[WIDTH-1:0];
    assign rem_fix  = rneg_q ? -rem_q[WIDTH-1:0]     : rem_q[WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        a_orig_d = a_orig_q;
        mb_d     = mb_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (hi_w) hi_d = w_data;
                if (lo_w) lo_d = w_data;
                if (start) begin
                    state_d  = S_CALC;
                    div_d    = op[1];
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    a_orig_d = a;
                    mb_d     = abs_b;
                    cnt_d    = '0;
                    acc_d    = {{WIDTH{1'b0}}, abs_a};
                    rem_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            S_CALC: begin
                if (div_q) begin
                    rem_d = div_ge ? div_diff[WIDTH:0] : div_sh[WIDTH:0];
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (!div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (mb_q == '0) begin
                    hi_d = a_orig_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            a_orig_q <= '0;
            mb_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            a_orig_q <= a_orig_d;
            mb_q     <= mb_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
Parametrised iterative multiply/divide unit for the multicycle CPU datapath. It sits beside the ALU and provides MULT, MULTU, DIV and DIVU, with results held in architectural HI/LO registers. Software can also write HI/LO directly (MTHI/MTLO). The controller starts an operation with a one-cycle handshake and stalls on `busy` until `done`.

Parameters:
- WIDTH, 32, operand/HI/LO width; must be ≥4 and even.
- CW, 6, iteration counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin operation; sampled only in IDLE.
- op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  in  WIDTH  multiplicand / dividend.
- b  in  WIDTH  multiplier / divisor.
- hi_w  in  1  write HI from w_data (MTHI).
- lo_w  in  1  write LO from w_data (MTLO).
- w_data  in  WIDTH  direct-write data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: HI/LO now hold the result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, hi=0, lo=0, internal registers cleared.
- Reset mid-operation: the operation is abandoned, same values as above at the next edge, no done pulse.
- States: IDLE, CALC, FIX.
  - IDLE: on an edge with start=1, latch op, |a|, |b| (signed ops: magnitude; unsigned ops: raw), the result sign flags and the original a. Counter=0. Go to CALC.
  - CALC: one radix-2 step per edge for WIDTH edges, then go to FIX.
    - MUL: shift-add over a 2*WIDTH-bit accumulator.
    - DIV: restoring shift-subtract using a WIDTH+1-bit partial remainder.
  - FIX: apply signs, write hi/lo, go to IDLE.
- Timing: start sampled at edge E0.
  - busy=1 from after E0 until edge E0+WIDTH+1.
  - At E0+WIDTH+1, hi/lo are written, busy→0 and done→1 for exactly one cycle.
  - Total latency: WIDTH+1 edges.
  - A new start may be accepted in the done cycle (state is already IDLE).
- start while busy=1: ignored; no queuing.
- Multiply result: {hi,lo} = full 2*WIDTH-bit product. For MULT, the product is negated when sign(a)≠sign(b).
- Divide result: lo = quotient, hi = remainder.
  - Signed quotient is negative when sign(a)≠sign(b).
  - Remainder takes the sign of the dividend (truncating division).
- Divide by zero (b=0, DIV or DIVU): lo = all ones, hi = a (original, unmodified). Still takes full latency and pulses done.
- Signed overflow (DIV of most-negative value by −1): lo = most-negative value, hi = 0. No exception is raised.
- Direct writes:
  - hi_w/lo_w write on the edge when busy=0 and the FSM is not writing results.
  - If start and hi_w/lo_w occur on the same edge, the direct write happens and the later result overwrites it.
  - hi_w/lo_w while busy=1: ignored.
- hi/lo are stable at all times except on the result edge, the direct-write edge and reset.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF, start at E0 → busy high for 33 cycles; done pulse after E0+33; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT, a=−3 (0xFFFFFFFD), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then MULT with a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0.
3. DIV, a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU, a=100, b=7 → lo=14, hi=2.
4. DIVU, a=7, b=0 → lo=0xFFFFFFFF, hi=7, done after 33 edges. Then DIV, a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
5. Start MULTU, then assert start with different operands and hi_w=1 at cycle 5 → both ignored; result matches the first operation only. After done, hi_w=1 with w_data=0x1234 → hi=0x1234 next edge, lo unchanged.
6. rst asserted at cycle 10 of a DIV → next edge busy=0, done=0, hi=lo=0, no later done pulse. A start issued after rst deasserts completes correctly. Repeat scenarios 1–4 scaled with WIDTH=8.
